instr_mem_loader: RTL

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_pkg.sv | 22 ++
 rtl/instr_mem_loader_if.sv | 27 ++
 rtl/defines.sv | 7 +
 rtl/loader_word_assembler.sv | 42 ++++
 rtl/register.sv | 20 ++
 rtl/instr_mem_loader.sv | 159 +++++++++++++++
 6 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and stream-format constants for the
// instruction memory loader.
package instr_mem_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_B0,
        S_B1,
        S_B2,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int BYTE_W       = 8;
    localparam int LEN_FIELD_W  = 12;
    localparam int LEN_HI_W     = LEN_FIELD_W - BYTE_W;
    localparam int B2_PAYLOAD_W = 3;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction memory write bus
// of the loader, with producer/loader views.
`ifndef INSTRUCTION_LEN
`include "defines.sv"
`endif

interface instr_mem_loader_if #(
    parameter int INSTR_LEN = `INSTRUCTION_LEN,
    parameter int ADDR_LEN  = `ADDRESS_LEN
);
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 im_we;
    logic [ADDR_LEN-1:0]  im_addr;
    logic [INSTR_LEN-1:0] im_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/defines.sv
// Global width defines shared by the core and its loaders.
// Included by files that need instruction/address widths.
`ifndef DEFINES_SV
`define DEFINES_SV
`define INSTRUCTION_LEN 19
`define ADDRESS_LEN 12
`endif

// File: rtl/loader_word_assembler.sv
// Collects B0/B1 and, on B2, loads the full instruction
// word into the output register driving the memory bus.
`ifndef INSTRUCTION_LEN
`include "defines.sv"
`endif

module loader_word_assembler #(
    parameter int INSTR_LEN = `INSTRUCTION_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_b0,
    input  logic                 en_b1,
    input  logic                 load,
    input  logic [7:0]           din,
    output logic [INSTR_LEN-1:0] word
);

    logic [7:0]           b0_q;
    logic [7:0]           b1_q;
    logic [INSTR_LEN-1:0] word_q;

    // partial bytes hold across stalls until replaced
    always_ff @(posedge clk) begin
        if (rst) begin
            b0_q <= '0;
            b1_q <= '0;
        end else begin
            if (en_b0) b0_q <= din;
            if (en_b1) b1_q <= din;
        end
    end

    // output word only changes when a legal B2 arrives
    always_ff @(posedge clk) begin
        if (rst)       word_q <= '0;
        else if (load) word_q <= {din[INSTR_LEN-17:0], b1_q, b0_q};
    end

    assign word = word_q;

endmodule

// File: rtl/register.sv
// Generic enable register with synchronous reset and a
// synchronous clear that takes priority over the enable.
module register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // state update: reset/clear to zero, else load on enable
    always_ff @(posedge clk) begin
        if (rst || clr) q <= '0;
        else if (en)    q <= d;
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: parses length, words and
// checksum, writes instruction memory, gates core reset.
`ifndef INSTRUCTION_LEN
`include "defines.sv"
`endif

module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int INSTR_LEN = `INSTRUCTION_LEN,
    parameter int ADDR_LEN  = `ADDRESS_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    instr_mem_loader_if.slave bus,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    state_t                state_q;
    state_t                state_d;
    logic                  we_q;
    logic                  in_ready;
    logic                  accept;
    logic                  go;
    logic [7:0]            len_lo_q;
    logic [LEN_HI_W-1:0]   len_hi_q;
    logic [LEN_FIELD_W-1:0] n_words;
    logic [LEN_FIELD_W-1:0] n_now;
    logic                  hi_bad;
    logic                  b2_bad;
    logic [ADDR_LEN-1:0]   cnt_q;
    logic [ADDR_LEN:0]     next_idx;
    logic                  more;
    logic [7:0]            acc_q;
    logic [INSTR_LEN-1:0]  word;

    assign accept   = bus.in_valid && in_ready;
    assign go       = start && (state_q == S_IDLE ||
                                state_q == S_DONE ||
                                state_q == S_ERROR);
    assign n_words  = {len_hi_q, len_lo_q};
    assign n_now    = {bus.in_data[LEN_HI_W-1:0], len_lo_q};
    assign hi_bad   = |bus.in_data[7:LEN_HI_W];
    assign b2_bad   = |bus.in_data[7:B2_PAYLOAD_W];
    assign next_idx = {1'b0, cnt_q} + (ADDR_LEN+1)'(1);
    assign more     = next_idx < (ADDR_LEN+1)'(n_words);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR:
                if (start) state_d = S_LEN_LO;
            S_LEN_LO:
                if (accept) state_d = S_LEN_HI;
            S_LEN_HI:
                if (accept) begin
                    if (hi_bad)          state_d = S_ERROR;
                    else if (n_now == 0) state_d = S_CHECK;
                    else                 state_d = S_B0;
                end
            S_B0:
                if (accept) state_d = S_B1;
            S_B1:
                if (accept) state_d = S_B2;
            S_B2:
                if (accept) begin
                    if (b2_bad)    state_d = S_ERROR;
                    else if (more) state_d = S_B0;
                    else           state_d = S_CHECK;
                end
            S_CHECK:
                if (accept) begin
                    if (bus.in_data == acc_q) state_d = S_DONE;
                    else                      state_d = S_ERROR;
                end
            default: state_d = S_IDLE;
        endcase
    end

    // outputs decoded from registered state only
    always_comb begin
        in_ready  = 1'b0;
        core_hold = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        unique case (state_q)
            S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_CHECK:
                in_ready = !we_q;
            S_DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
            end
            S_ERROR: error = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // one-cycle write strobe after a legal B2
    always_ff @(posedge clk) begin
        if (rst) we_q <= 1'b0;
        else     we_q <= accept && state_q == S_B2 && !b2_bad;
    end

    // capture the word count field
    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo_q <= '0;
            len_hi_q <= '0;
        end else if (accept) begin
            if (state_q == S_LEN_LO) len_lo_q <= bus.in_data;
            if (state_q == S_LEN_HI)
                len_hi_q <= bus.in_data[LEN_HI_W-1:0];
        end
    end

    register #(.WIDTH(ADDR_LEN)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (go),
        .en  (we_q),
        .d   (cnt_q + ADDR_LEN'(1)),
        .q   (cnt_q)
    );

    register #(.WIDTH(8)) u_acc (
        .clk (clk),
        .rst (rst),
        .clr (go),
        .en  (accept && state_q != S_CHECK),
        .d   (acc_q ^ bus.in_data),
        .q   (acc_q)
    );

    loader_word_assembler #(.INSTR_LEN(INSTR_LEN)) u_asm (
        .clk   (clk),
        .rst   (rst),
        .en_b0 (accept && state_q == S_B0),
        .en_b1 (accept && state_q == S_B1),
        .load  (accept && state_q == S_B2 && !b2_bad),
        .din   (bus.in_data),
        .word  (word)
    );

    assign bus.in_ready = in_ready;
    assign bus.im_we    = we_q;
    assign bus.im_addr  = cnt_q;
    assign bus.im_wdata = word;

endmodule
